// File: rtl/bsg_link_pearl_pkg.sv
// Shared definitions for the SDR link reset sequencer.
//   bsg_sdr_link_seq_state_e   : bring-up FSM state encoding
//   bsg_sdr_link_seq_step_gp   : default hold time of each release step
//   bsg_sdr_link_seq_token_gp  : default width of the token-reset pulse
//   bsg_sdr_link_seq_max       : larger of two durations, used to size the counter
package bsg_link_pearl_pkg;

  typedef enum logic [2:0] {
    e_seq_idle     = 3'd0,
    e_seq_link_en  = 3'd1,
    e_seq_token_hi = 3'd2,
    e_seq_token_lo = 3'd3,
    e_seq_up_rel   = 3'd4,
    e_seq_down_rel = 3'd5,
    e_seq_ds_rel   = 3'd6,
    e_seq_done     = 3'd7
  } bsg_sdr_link_seq_state_e;

  localparam int bsg_sdr_link_seq_step_gp  = 16;
  localparam int bsg_sdr_link_seq_token_gp = 4;

  function automatic int bsg_sdr_link_seq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bsg_sdr_link_reset_sequencer_if.sv
// Bundle of the sequencer's control request and reset/status outputs.
//   start, abort             : bring-up request and cancel (controller -> sequencer)
//   token_reset ... done     : reset, disable and status lines (sequencer -> link/controller)
// master : the controller side that requests bring-up and watches status
// slave  : the sequencer side that produces the resets
interface bsg_sdr_link_reset_sequencer_if;

  logic start;
  logic abort;
  logic token_reset;
  logic uplink_reset;
  logic downlink_reset;
  logic downstream_reset;
  logic link_i_disable;
  logic link_o_disable;
  logic busy;
  logic done;

  modport master (
    output start, abort,
    input  token_reset, uplink_reset, downlink_reset, downstream_reset,
           link_i_disable, link_o_disable, busy, done
  );

  modport slave (
    input  start, abort,
    output token_reset, uplink_reset, downlink_reset, downstream_reset,
           link_i_disable, link_o_disable, busy, done
  );

endinterface

// File: rtl/bsg_sdr_link_reset_sequencer.sv
// Ordered reset release for an SDR link: enable the link I/O, pulse the token
// reset, then release uplink, downlink and downstream resets one step apart.
// Ports:
//   core_clk_i          sole clock
//   core_reset_i        synchronous active-high reset (highest priority)
//   start_i             begin bring-up, honoured only in IDLE
//   abort_i             return to IDLE and reassert all resets
//   token_reset_o       link token reset
//   uplink_reset_o      core uplink reset
//   downlink_reset_o    downlink reset
//   downstream_reset_o  core downstream reset
//   link_i_disable_o    input-link disable
//   link_o_disable_o    output-link disable
//   busy_o              sequence in progress
//   done_o              link released and operational
module bsg_sdr_link_reset_sequencer
  import bsg_link_pearl_pkg::*;
#(
  parameter int step_cycles_p  = bsg_sdr_link_seq_step_gp,
  parameter int token_cycles_p = bsg_sdr_link_seq_token_gp
) (
  input  logic core_clk_i,
  input  logic core_reset_i,
  input  logic start_i,
  input  logic abort_i,
  output logic token_reset_o,
  output logic uplink_reset_o,
  output logic downlink_reset_o,
  output logic downstream_reset_o,
  output logic link_i_disable_o,
  output logic link_o_disable_o,
  output logic busy_o,
  output logic done_o
);

  // One extra bit beyond clog2 keeps the duration-1 load from wrapping.
  localparam int cnt_w_lp = $clog2(bsg_sdr_link_seq_max(step_cycles_p, token_cycles_p)) + 1;
  localparam logic [cnt_w_lp-1:0] step_ld_lp  = cnt_w_lp'(step_cycles_p - 1);
  localparam logic [cnt_w_lp-1:0] token_ld_lp = cnt_w_lp'(token_cycles_p - 1);

  bsg_sdr_link_seq_state_e state_r, state_n;
  logic [cnt_w_lp-1:0]     cnt_r, cnt_n;
  bsg_sdr_link_seq_state_e step_nxt;
  logic [cnt_w_lp-1:0]     step_ld;
  logic [7:0]              outs;

  always_ff @(posedge core_clk_i) begin
    if (core_reset_i) begin
      state_r <= e_seq_idle;
      cnt_r   <= '0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
    end
  end

  // Successor of each timed step and the counter value it is entered with.
  always_comb begin
    step_nxt = e_seq_idle;
    step_ld  = '0;
    case (state_r)
      e_seq_link_en:  begin step_nxt = e_seq_token_hi; step_ld = token_ld_lp; end
      e_seq_token_hi: begin step_nxt = e_seq_token_lo; step_ld = step_ld_lp;  end
      e_seq_token_lo: begin step_nxt = e_seq_up_rel;   step_ld = step_ld_lp;  end
      e_seq_up_rel:   begin step_nxt = e_seq_down_rel; step_ld = step_ld_lp;  end
      e_seq_down_rel: begin step_nxt = e_seq_ds_rel;   step_ld = step_ld_lp;  end
      e_seq_ds_rel:   begin step_nxt = e_seq_done;     step_ld = '0;          end
      default:        begin step_nxt = e_seq_idle;     step_ld = '0;          end
    endcase
  end

  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    if (abort_i) begin
      state_n = e_seq_idle;
      cnt_n   = '0;
    end else begin
      case (state_r)
        e_seq_idle: begin
          if (start_i) begin
            state_n = e_seq_link_en;
            cnt_n   = step_ld_lp;
          end
        end
        e_seq_done: begin
          cnt_n = '0;
        end
        default: begin
          if (cnt_r == '0) begin
            state_n = step_nxt;
            cnt_n   = step_ld;
          end else begin
            cnt_n = cnt_r - cnt_w_lp'(1);
          end
        end
      endcase
    end
  end

  // {token, uplink, downlink, downstream, link_i_dis, link_o_dis, busy, done}
  always_comb begin
    outs = 8'b0111_1100;
    case (state_r)
      e_seq_idle:     outs = 8'b0111_1100;
      e_seq_link_en:  outs = 8'b0111_0010;
      e_seq_token_hi: outs = 8'b1111_0010;
      e_seq_token_lo: outs = 8'b0111_0010;
      e_seq_up_rel:   outs = 8'b0011_0010;
      e_seq_down_rel: outs = 8'b0001_0010;
      e_seq_ds_rel:   outs = 8'b0000_0010;
      e_seq_done:     outs = 8'b0000_0001;
      default:        outs = 8'b0111_1100;
    endcase
  end

  assign token_reset_o      = outs[7];
  assign uplink_reset_o     = outs[6];
  assign downlink_reset_o   = outs[5];
  assign downstream_reset_o = outs[4];
  assign link_i_disable_o   = outs[3];
  assign link_o_disable_o   = outs[2];
  assign busy_o             = outs[1];
  assign done_o             = outs[0];

endmodule

// File: tb/tb_bsg_sdr_link_reset_sequencer.sv
// Bench for the SDR link reset sequencer: one instance with step=4/token=2 and
// one with step=1/token=1, a timeline model of the release sequence, a
// directed preamble followed by random start/abort/reset traffic.
module tb_bsg_sdr_link_reset_sequencer;

  localparam int S_A = 4;
  localparam int T_A = 2;
  localparam int S_B = 1;
  localparam int T_B = 1;

  localparam int I_TOK  = 7;
  localparam int I_UP   = 6;
  localparam int I_DN   = 5;
  localparam int I_DS   = 4;
  localparam int I_LI   = 3;
  localparam int I_LO   = 2;
  localparam int I_BUSY = 1;
  localparam int I_DONE = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a = 1'b1;
  logic rst_b = 1'b1;

  bsg_sdr_link_reset_sequencer_if ifa ();
  bsg_sdr_link_reset_sequencer_if ifb ();

  bsg_sdr_link_reset_sequencer #(.step_cycles_p(S_A), .token_cycles_p(T_A)) dut_a (
    .core_clk_i         (clk),
    .core_reset_i       (rst_a),
    .start_i            (ifa.start),
    .abort_i            (ifa.abort),
    .token_reset_o      (ifa.token_reset),
    .uplink_reset_o     (ifa.uplink_reset),
    .downlink_reset_o   (ifa.downlink_reset),
    .downstream_reset_o (ifa.downstream_reset),
    .link_i_disable_o   (ifa.link_i_disable),
    .link_o_disable_o   (ifa.link_o_disable),
    .busy_o             (ifa.busy),
    .done_o             (ifa.done)
  );

  bsg_sdr_link_reset_sequencer #(.step_cycles_p(S_B), .token_cycles_p(T_B)) dut_b (
    .core_clk_i         (clk),
    .core_reset_i       (rst_b),
    .start_i            (ifb.start),
    .abort_i            (ifb.abort),
    .token_reset_o      (ifb.token_reset),
    .uplink_reset_o     (ifb.uplink_reset),
    .downlink_reset_o   (ifb.downlink_reset),
    .downstream_reset_o (ifb.downstream_reset),
    .link_i_disable_o   (ifb.link_i_disable),
    .link_o_disable_o   (ifb.link_o_disable),
    .busy_o             (ifb.busy),
    .done_o             (ifb.done)
  );

  logic [7:0] got_a, got_b;
  assign got_a = {ifa.token_reset, ifa.uplink_reset, ifa.downlink_reset, ifa.downstream_reset,
                  ifa.link_i_disable, ifa.link_o_disable, ifa.busy, ifa.done};
  assign got_b = {ifb.token_reset, ifb.uplink_reset, ifb.downlink_reset, ifb.downstream_reset,
                  ifb.link_i_disable, ifb.link_o_disable, ifb.busy, ifb.done};

  int cyc      = 0;
  bit chk_en   = 1'b0;
  int n_assert = 0;
  int n_fail   = 0;

  // Timeline model: act says a bring-up is in flight, pos counts cycles since
  // the start was accepted (1 = first cycle of link enable).
  bit act_a = 1'b0;
  int pos_a = 0;
  bit act_b = 1'b0;
  int pos_b = 0;

  always @(posedge clk) begin
    if (rst_a || ifa.abort) begin
      act_a <= 1'b0;
      pos_a <= 0;
    end else if (!act_a) begin
      if (ifa.start) begin
        act_a <= 1'b1;
        pos_a <= 1;
      end
    end else if (pos_a < 5 * S_A + T_A + 1) begin
      pos_a <= pos_a + 1;
    end
  end

  always @(posedge clk) begin
    if (rst_b || ifb.abort) begin
      act_b <= 1'b0;
      pos_b <= 0;
    end else if (!act_b) begin
      if (ifb.start) begin
        act_b <= 1'b1;
        pos_b <= 1;
      end
    end else if (pos_b < 5 * S_B + T_B + 1) begin
      pos_b <= pos_b + 1;
    end
  end

  // Expected {tok,up,dn,ds,li,lo,busy,done} from elapsed time in the sequence.
  function automatic logic [7:0] exp_vec(input bit a, input int p, input int s, input int t);
    int e;
    if (!a) return 8'b0111_1100;
    e = p - 1;
    if (e < s)             return 8'b0111_0010;
    if (e < s + t)         return 8'b1111_0010;
    if (e < 2 * s + t)     return 8'b0111_0010;
    if (e < 3 * s + t)     return 8'b0011_0010;
    if (e < 4 * s + t)     return 8'b0001_0010;
    if (e < 5 * s + t)     return 8'b0000_0010;
    return 8'b0000_0001;
  endfunction

  typedef struct {
    int   cyc;
    int   dut;
    int   idx;
    logic val;
  } lit_t;
  lit_t  lits[$];
  string bit_name [8] = '{"done", "busy", "link_o_dis", "link_i_dis",
                          "downstream_reset", "downlink_reset", "uplink_reset", "token_reset"};

  function automatic void add_lit(input int c, input int d, input int i, input logic v);
    lit_t l;
    l.cyc = c; l.dut = d; l.idx = i; l.val = v;
    lits.push_back(l);
  endfunction

  logic [7:0] exp_a, exp_b;
  logic       lit_got;

  always @(negedge clk) begin
    if (chk_en) begin
      exp_a = exp_vec(act_a, pos_a, S_A, T_A);
      exp_b = exp_vec(act_b, pos_b, S_B, T_B);
      n_assert = n_assert + 1;
      if (got_a !== exp_a) begin
        n_fail = n_fail + 1;
        $display("FAIL dut_a_outputs cycle %0d: got %b required %b", cyc, got_a, exp_a);
      end
      n_assert = n_assert + 1;
      if (got_b !== exp_b) begin
        n_fail = n_fail + 1;
        $display("FAIL dut_b_outputs cycle %0d: got %b required %b", cyc, got_b, exp_b);
      end
      foreach (lits[i]) begin
        if (lits[i].cyc == cyc) begin
          lit_got = (lits[i].dut == 0) ? got_a[lits[i].idx] : got_b[lits[i].idx];
          n_assert = n_assert + 1;
          if (lit_got !== lits[i].val) begin
            n_fail = n_fail + 1;
            $display("FAIL literal_%s dut %0d cycle %0d: got %b required %b",
                     bit_name[lits[i].idx], lits[i].dut, cyc, lit_got, lits[i].val);
          end
        end
      end
    end
  end

  task automatic goto(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
      cyc = cyc + 1;
    end
  endtask

  initial begin
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;

    // reset state
    add_lit(2, 0, I_TOK, 1'b0);  add_lit(2, 0, I_UP, 1'b1);
    add_lit(2, 0, I_LI, 1'b1);   add_lit(2, 0, I_BUSY, 1'b0);
    // nominal bring-up, start at 10
    add_lit(10, 0, I_LI, 1'b1);  add_lit(11, 0, I_LI, 1'b0);  add_lit(11, 0, I_LO, 1'b0);
    add_lit(14, 0, I_TOK, 1'b0); add_lit(15, 0, I_TOK, 1'b1); add_lit(16, 0, I_TOK, 1'b1);
    add_lit(17, 0, I_TOK, 1'b0);
    add_lit(20, 0, I_UP, 1'b1);  add_lit(21, 0, I_UP, 1'b0);
    add_lit(24, 0, I_DN, 1'b1);  add_lit(25, 0, I_DN, 1'b0);
    add_lit(28, 0, I_DS, 1'b1);  add_lit(29, 0, I_DS, 1'b0);
    add_lit(32, 0, I_DONE, 1'b0); add_lit(33, 0, I_DONE, 1'b1);
    // abort inside the token pulse, then restart at 60
    add_lit(56, 0, I_TOK, 1'b1); add_lit(57, 0, I_TOK, 1'b0); add_lit(57, 0, I_BUSY, 1'b0);
    add_lit(57, 0, I_LI, 1'b1);  add_lit(57, 0, I_UP, 1'b1);
    add_lit(82, 0, I_DONE, 1'b0); add_lit(83, 0, I_DONE, 1'b1);
    // start+abort together in IDLE
    add_lit(91, 0, I_BUSY, 1'b0); add_lit(91, 0, I_LI, 1'b1);
    // core reset during downlink release, then idle without a start
    add_lit(112, 0, I_UP, 1'b1); add_lit(112, 0, I_DS, 1'b1); add_lit(112, 0, I_BUSY, 1'b0);
    add_lit(120, 0, I_BUSY, 1'b0); add_lit(120, 0, I_LI, 1'b1);
    // minimum-duration instance, start at 10
    add_lit(11, 1, I_LI, 1'b0);  add_lit(12, 1, I_TOK, 1'b1); add_lit(13, 1, I_TOK, 1'b0);
    add_lit(16, 1, I_DONE, 1'b0); add_lit(17, 1, I_DONE, 1'b1);

    goto(1);
    chk_en = 1'b1;
    goto(3);
    rst_a = 1'b0; rst_b = 1'b0;

    goto(10); ifa.start = 1'b1; ifb.start = 1'b1;
    goto(11); ifa.start = 1'b0; ifb.start = 1'b0;
    goto(40); ifa.start = 1'b1;
    goto(41); ifa.start = 1'b0;
    goto(45); ifa.abort = 1'b1;
    goto(46); ifa.abort = 1'b0;
    goto(50); ifa.start = 1'b1;
    goto(51); ifa.start = 1'b0;
    goto(56); ifa.abort = 1'b1;
    goto(57); ifa.abort = 1'b0;
    goto(60); ifa.start = 1'b1;
    goto(61); ifa.start = 1'b0;
    goto(72); ifa.start = 1'b1;
    goto(73); ifa.start = 1'b0;
    goto(85); ifa.abort = 1'b1;
    goto(86); ifa.abort = 1'b0;
    goto(90); ifa.start = 1'b1; ifa.abort = 1'b1;
    goto(91); ifa.start = 1'b0; ifa.abort = 1'b0;
    goto(95); ifa.start = 1'b1;
    goto(96); ifa.start = 1'b0;
    goto(111); rst_a = 1'b1;
    goto(112); rst_a = 1'b0;
    goto(121);

    for (int i = 0; i < 3000; i++) begin
      rst_a     = ($urandom_range(0, 99) == 0);
      ifa.start = ($urandom_range(0, 7) == 0);
      ifa.abort = ($urandom_range(0, 59) == 0);
      rst_b     = ($urandom_range(0, 79) == 0);
      ifb.start = ($urandom_range(0, 5) == 0);
      ifb.abort = ($urandom_range(0, 29) == 0);
      goto(cyc + 1);
    end

    rst_a = 1'b0; rst_b = 1'b0;
    ifa.start = 1'b0; ifa.abort = 1'b0;
    ifb.start = 1'b0; ifb.abort = 1'b0;
    goto(cyc + 3);
    #5;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bsg_sdr_link_reset_sequencer.md
BSG_SDR_LINK_RESET_SEQUENCER -- requirements
Module: bsg_sdr_link_reset_sequencer

Interface
REQ-001 SHALL have parameter step_cycles_p, default 16: the number of cycles each release step is held; legal range 1..65535.
REQ-002 SHALL have parameter token_cycles_p, default 4: the width of the token-reset pulse in cycles; legal range 1..65535.
REQ-003 SHALL have the following ports: one clock; reset is synchronous and active-high.
- core_clk_i  input  1  sole clock.
- core_reset_i  input  1  synchronous active-high reset.
- start_i  input  1  begin bring-up; sampled only in IDLE.
- abort_i  input  1  return to IDLE and reassert all resets.
- token_reset_o  output  1  drives the link's async token reset.
- uplink_reset_o  output  1  drives the core uplink reset.
- downlink_reset_o  output  1  drives the async downlink reset.
- downstream_reset_o  output  1  drives the core downstream reset.
- link_i_disable_o  output  1  async input-link disable.
- link_o_disable_o  output  1  async output-link disable.
- busy_o  output  1  sequence in progress.
- done_o  output  1  link released and operational.

Function
REQ-004 SHALL implement a Moore FSM with states IDLE, LINK_EN, TOKEN_HI, TOKEN_LO, UP_REL, DOWN_REL, DS_REL and DONE; all outputs SHALL be decoded from the registered state only.
REQ-005 Per-state outputs (order: token, uplink, downlink, downstream, link_i_dis, link_o_dis) SHALL be:
- IDLE: 0,1,1,1,1,1
- LINK_EN: 0,1,1,1,0,0
- TOKEN_HI: 1,1,1,1,0,0
- TOKEN_LO: 0,1,1,1,0,0
- UP_REL: 0,0,1,1,0,0
- DOWN_REL: 0,0,0,1,0,0
- DS_REL and DONE: 0,0,0,0,0,0
REQ-006 busy_o SHALL be 1 in every state other than IDLE and DONE; done_o SHALL be 1 only in DONE.
REQ-007 If start_i=1 in IDLE at cycle t, the state SHALL be LINK_EN at cycle t+1.
REQ-008 LINK_EN, TOKEN_LO, UP_REL, DOWN_REL and DS_REL SHALL each last exactly step_cycles_p cycles; TOKEN_HI SHALL last exactly token_cycles_p cycles.
REQ-009 State order SHALL be LINK_EN->TOKEN_HI->TOKEN_LO->UP_REL->DOWN_REL->DS_REL->DONE; DONE is reached at cycle t+1+5*step_cycles_p+token_cycles_p.
REQ-010 A single down-counter SHALL load (duration-1) on every state entry and advance the state when it reaches 0; its width SHALL be clog2 of the larger parameter plus 1; it SHALL never wrap.
REQ-011 start_i SHALL be ignored outside IDLE, including in DONE; DONE SHALL hold until abort_i or core_reset_i.
REQ-012 abort_i=1 in any state SHALL force IDLE on the next cycle; if start_i and abort_i are high together in IDLE, abort_i SHALL win and the state SHALL remain IDLE.
REQ-013 An abort in TOKEN_HI SHALL drop token_reset_o on the next cycle; a restart SHALL replay the full sequence, including a full-length token pulse.
REQ-014 No release step SHALL ever be skipped or reordered, for any parameter values.

Reset
REQ-015 core_reset_i SHALL take priority over start_i and abort_i; the cycle after it is sampled high, the state SHALL be IDLE and the counter 0.
REQ-016 While in reset, the outputs SHALL be token=0, uplink=1, downlink=1, downstream=1, link_i_dis=1, link_o_dis=1, busy=0 and done=0.
REQ-017 core_reset_i asserted mid-sequence SHALL behave identically to abort_i.

Structure
REQ-018 The state enum bsg_sdr_link_seq_state_e SHALL live in bsg_link_pearl_pkg; the parameter defaults SHALL live there as bsg_sdr_link_seq_step_gp and bsg_sdr_link_seq_token_gp.
REQ-019 The block SHALL have no sub-modules: the counter and FSM are inline, with one state register and one counter register.

Verification (step_cycles_p=4, token_cycles_p=2 unless stated)
REQ-020 Reset then start_i pulse at t=10 -> link disables fall at t=11; token_reset_o is high during t=15..16; uplink_reset_o falls at t=21; downlink_reset_o falls at t=25; downstream_reset_o falls at t=29; done_o rises at t=33.
REQ-021 abort_i at t=16 (TOKEN_HI) -> at t=17 all resets are reasserted, token=0, disables=1 and busy=0; a restart at t=20 yields done_o at t=43.
REQ-022 start_i and abort_i both high in IDLE -> the state stays IDLE and all outputs are unchanged.
REQ-023 start_i pulsed in DONE and during UP_REL -> no change of state or outputs and no timing shift.
REQ-024 core_reset_i asserted during DOWN_REL -> the next cycle matches REQ-016; releasing reset without a start holds IDLE.
REQ-025 With step_cycles_p=1 and token_cycles_p=1 -> done_o rises at t+7 after a start at t, with every state visited exactly once.
